// File: rtl/tt_keyverify_pkg.sv
// Shared types and defaults for the key-verify lock: FSM state, key width and
// the default deny time and try limit.
package tt_keyverify_pkg;

  localparam int KEY_W           = 4;
  localparam int DENY_CYCLES_DEF = 16;
  localparam int MAX_TRIES_DEF   = 3;

  typedef enum logic [2:0] {
    ST_EMPTY = 3'd0,
    ST_ENTRY = 3'd1,
    ST_GRANT = 3'd2,
    ST_DENY  = 3'd3,
    ST_LOCK  = 3'd4
  } state_e;

endpackage

// File: rtl/tt_keyverify_sync.sv
// Two-flop synchronizer for an asynchronous pin, plus a registered copy of the
// synchronized level so a one-cycle rising-edge pulse can be formed.
module tt_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise
);

  logic s1_q, s2_q, prev_q;
  logic s1_d, s2_d, prev_d;

  always_comb begin
    s1_d   = d;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~prev_q;

endmodule

// File: rtl/tt_keyverify.sv
// Key-verify lock: a 4-bit key is captured, the user shifts in a guess bit by
// bit and submits; wrong guesses hold fail for a while and too many lock out.
module tt_keyverify
  import tt_keyverify_pkg::*;
#(
  parameter int DENY_CYCLES = DENY_CYCLES_DEF,
  parameter int MAX_TRIES   = MAX_TRIES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_load,
  input  logic             entry_bit,
  input  logic             entry_clk,
  input  logic             submit,
  output logic             match,
  output logic             fail,
  output logic             locked,
  output logic [1:0]       attempts,
  output logic [2:0]       bitcnt
);

  localparam int CNT_W = (DENY_CYCLES > 1) ? $clog2(DENY_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DENY_LOAD = CNT_W'(DENY_CYCLES - 1);
  localparam logic [1:0]       TRY_MAX   = 2'(MAX_TRIES);
  localparam logic [2:0]       FULL      = 3'(KEY_W);

  logic load_rise, ec_rise, sub_rise, bit_lvl;
  logic load_lvl_unused, ec_lvl_unused, sub_lvl_unused, bit_rise_unused;

  tt_sync_edge u_load (.clk(clk), .rst_n(rst_n), .d(key_load),
                       .level(load_lvl_unused), .rise(load_rise));
  tt_sync_edge u_eclk (.clk(clk), .rst_n(rst_n), .d(entry_clk),
                       .level(ec_lvl_unused), .rise(ec_rise));
  tt_sync_edge u_sub  (.clk(clk), .rst_n(rst_n), .d(submit),
                       .level(sub_lvl_unused), .rise(sub_rise));
  tt_sync_edge u_bit  (.clk(clk), .rst_n(rst_n), .d(entry_bit),
                       .level(bit_lvl), .rise(bit_rise_unused));

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d, shift_q, shift_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [1:0]       attempts_q, attempts_d, att_next;
  logic [CNT_W-1:0] deny_cnt_q, deny_cnt_d;
  logic             match_q, match_d, fail_q, fail_d, locked_q, locked_d;

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    shift_d    = shift_q;
    bitcnt_d   = bitcnt_q;
    attempts_d = attempts_q;
    deny_cnt_d = deny_cnt_q;
    att_next   = (attempts_q == TRY_MAX) ? attempts_q : attempts_q + 2'd1;
    case (state_q)
      ST_EMPTY: begin
        if (load_rise) begin
          key_d    = key_in;
          shift_d  = '0;
          bitcnt_d = '0;
          state_d  = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        // Submit outranks key_load, which outranks entry_clk; losers are dropped.
        if (sub_rise) begin
          if (bitcnt_q == FULL && shift_q == key_q) begin
            state_d = ST_GRANT;
          end else begin
            attempts_d = att_next;
            if (att_next == TRY_MAX) begin
              state_d = ST_LOCK;
            end else begin
              state_d    = ST_DENY;
              deny_cnt_d = DENY_LOAD;
            end
          end
        end else if (load_rise) begin
          key_d    = key_in;
          shift_d  = '0;
          bitcnt_d = '0;
        end else if (ec_rise) begin
          shift_d = {shift_q[KEY_W-2:0], bit_lvl};
          if (bitcnt_q != FULL) bitcnt_d = bitcnt_q + 3'd1;
        end
      end
      ST_DENY: begin
        if (deny_cnt_q == '0) begin
          shift_d  = '0;
          bitcnt_d = '0;
          state_d  = ST_ENTRY;
        end else begin
          deny_cnt_d = deny_cnt_q - 1'b1;
        end
      end
      ST_GRANT: begin
        if (load_rise) begin
          key_d      = key_in;
          shift_d    = '0;
          bitcnt_d   = '0;
          attempts_d = '0;
          state_d    = ST_ENTRY;
        end
      end
      ST_LOCK: state_d = ST_LOCK;
      default: state_d = ST_EMPTY;
    endcase
    match_d  = (state_d == ST_GRANT);
    fail_d   = (state_d == ST_DENY);
    locked_d = (state_d == ST_LOCK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      key_q      <= '0;
      shift_q    <= '0;
      bitcnt_q   <= '0;
      attempts_q <= '0;
      deny_cnt_q <= '0;
      match_q    <= 1'b0;
      fail_q     <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      attempts_q <= attempts_d;
      deny_cnt_q <= deny_cnt_d;
      match_q    <= match_d;
      fail_q     <= fail_d;
      locked_q   <= locked_d;
    end
  end

  assign match    = match_q;
  assign fail     = fail_q;
  assign locked   = locked_q;
  assign attempts = attempts_q;
  assign bitcnt   = bitcnt_q;

endmodule

// File: tb/tb_tt_keyverify.sv
// Bench for tt_keyverify: directed scenarios plus randomized button presses,
// every cycle compared against an event/time-based model of the lock.
module tb_tt_keyverify;

  localparam int DENY = 16;
  localparam int MAXT = 3;
  localparam int M_EMPTY = 0, M_ENTRY = 1, M_GRANT = 2, M_DENY = 3, M_LOCK = 4;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [3:0] key_in = 4'd0;
  logic       key_load = 1'b0, entry_bit = 1'b0, entry_clk = 1'b0, submit = 1'b0;
  logic       match, fail, locked;
  logic [1:0] attempts;
  logic [2:0] bitcnt;

  always #5 clk = ~clk;

  tt_keyverify #(.DENY_CYCLES(DENY), .MAX_TRIES(MAXT)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_load(key_load),
    .entry_bit(entry_bit), .entry_clk(entry_clk), .submit(submit),
    .match(match), .fail(fail), .locked(locked),
    .attempts(attempts), .bitcnt(bitcnt)
  );

  int total = 0, bad = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: press events take effect 3 edges after the pin is raised;
  // a deny lasts DENY edges measured from the edge that entered it.
  typedef struct {
    int         act;
    bit         sub, ld, ec, eb;
    logic [3:0] kin;
  } ev_t;
  ev_t pend[$];

  int         m_st, m_bits, m_att, m_deny_end, m_shifts;
  logic [3:0] m_key, m_shift;

  task automatic m_clear();
    m_shift = 4'd0; m_bits = 0; m_shifts = 0;
  endtask

  task automatic m_reset();
    m_st = M_EMPTY; m_key = 4'd0; m_att = 0; m_deny_end = -1;
    m_clear();
    pend.delete();
  endtask

  task automatic m_apply(input ev_t e);
    if (m_st == M_DENY || e.act == m_deny_end) return;
    case (m_st)
      M_EMPTY: if (e.ld) begin m_key = e.kin; m_clear(); m_st = M_ENTRY; end
      M_ENTRY: begin
        if (e.sub) begin
          if (m_bits == 4 && m_shift == m_key) m_st = M_GRANT;
          else begin
            m_att++;
            if (m_att >= MAXT) m_st = M_LOCK;
            else begin m_st = M_DENY; m_deny_end = e.act + DENY; end
          end
        end else if (e.ld) begin
          m_key = e.kin; m_clear();
        end else if (e.ec) begin
          m_shift = {m_shift[2:0], e.eb};
          m_shifts++;
          if (m_bits < 4) m_bits++;
        end
      end
      M_GRANT: if (e.ld) begin m_key = e.kin; m_clear(); m_att = 0; m_st = M_ENTRY; end
      default: ;
    endcase
  endtask

  function automatic logic [7:0] m_out();
    return {m_st == M_GRANT, m_st == M_DENY, m_st == M_LOCK, 2'(m_att), 3'(m_bits)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rst_n) begin
      if (m_st == M_DENY && cyc >= m_deny_end) begin m_st = M_ENTRY; m_clear(); end
      while (pend.size() > 0 && pend[0].act == cyc) m_apply(pend.pop_front());
    end
    chk("out", {match, fail, locked, attempts, bitcnt}, m_out());
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic raise(input bit sub, input bit ld, input bit ec, input bit eb,
                       input logic [3:0] kin);
    ev_t e;
    key_in = kin; entry_bit = eb;
    submit = sub; key_load = ld; entry_clk = ec;
    e.act = cyc + 3; e.sub = sub; e.ld = ld; e.ec = ec; e.eb = eb; e.kin = kin;
    pend.push_back(e);
  endtask

  task automatic lower();
    submit = 1'b0; key_load = 1'b0; entry_clk = 1'b0;
  endtask

  task automatic press(input bit sub, input bit ld, input bit ec, input bit eb,
                       input logic [3:0] kin);
    raise(sub, ld, ec, eb, kin);
    wait_ticks(3);
    lower();
    wait_ticks(3);
  endtask

  task automatic load(input logic [3:0] k);
    press(1'b0, 1'b1, 1'b0, 1'b0, k);
  endtask

  task automatic enter(input bit b);
    press(1'b0, 1'b0, 1'b1, b, key_in);
  endtask

  task automatic do_submit();
    press(1'b1, 1'b0, 1'b0, entry_bit, key_in);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    lower();
    #1;
    chk("rst_async", {match, fail, locked, attempts, bitcnt}, 8'h00);
    wait_ticks(2);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    m_reset();
    wait_ticks(3);
    chk("reset_state", {match, fail, locked, attempts, bitcnt}, 8'h00);
    #2 rst_n = 1'b1;
    wait_ticks(2);

    // Correct key, match exactly two edges after the submit is first sampled.
    do_reset();
    load(4'b1010);
    enter(1); enter(0); enter(1); enter(0);
    raise(1'b1, 1'b0, 1'b0, 1'b0, key_in);
    wait_ticks(2);
    chk("grant_early", match, 1'b0);
    tick();
    chk("grant_n2", match, 1'b1);
    chk("grant_att", attempts, 2'd0);
    chk("grant_bits", bitcnt, 3'd4);
    lower();
    wait_ticks(3);

    // Wrong guess: fail held exactly DENY cycles, then entry with no bits.
    do_reset();
    load(4'b0110);
    enter(0); enter(1); enter(1); enter(1);
    raise(1'b1, 1'b0, 1'b0, 1'b1, key_in);
    wait_ticks(3);
    lower();
    n = 0;
    while (fail === 1'b1 && n < 100) begin n++; tick(); end
    chk("deny_len", n, DENY);
    chk("deny_att", attempts, 2'd1);
    chk("deny_bits", bitcnt, 3'd0);
    enter(1);
    chk("after_deny_entry", bitcnt, 3'd1);

    // Three wrong submits lock out; everything else is ignored until reset.
    do_reset();
    load(4'b1001);
    enter(1); enter(0);
    do_submit(); wait_ticks(20);
    enter(0); enter(0); enter(0); enter(0);
    do_submit(); wait_ticks(20);
    enter(0); enter(0); enter(0); enter(0);
    do_submit();
    chk("lock_on", locked, 1'b1);
    chk("lock_att", attempts, 2'd3);
    load(4'b0000); enter(1); do_submit();
    chk("lock_hold", {match, fail, locked, attempts}, 5'b00111);
    do_reset();
    chk("lock_cleared", {match, fail, locked, attempts, bitcnt}, 8'h00);

    // Submit and entry_clk together with 3 bits: fails, bit not shifted.
    do_reset();
    load(4'b1100);
    enter(1); enter(1); enter(0);
    press(1'b1, 1'b0, 1'b1, 1'b0, key_in);
    chk("simul_fail", fail, 1'b1);
    chk("simul_att", attempts, 2'd1);
    chk("simul_bits", bitcnt, 3'd3);
    wait_ticks(20);

    // Over-long entry keeps the last four bits.
    do_reset();
    load(4'b0011);
    enter(1); enter(1); enter(0); enter(0); enter(1); enter(1);
    chk("long_bits", bitcnt, 3'd4);
    do_submit();
    chk("long_match", match, 1'b1);

    // Reset in the middle of a deny, then a submit with no key loaded.
    do_reset();
    load(4'b0101);
    enter(1);
    do_submit();
    wait_ticks(7);
    chk("deny_mid", fail, 1'b1);
    do_reset();
    chk("deny_rst", {match, fail, locked, attempts, bitcnt}, 8'h00);
    do_submit();
    enter(1);
    chk("empty_ignore", {match, fail, locked, attempts, bitcnt}, 8'h00);

    // Randomized presses with a bias toward entering the right key.
    do_reset();
    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3 || (m_st == M_LOCK && $urandom_range(0, 3) == 0)) begin
        do_reset();
      end else if (r < 15) begin
        load(4'($urandom));
      end else if (r < 30) begin
        do_submit();
      end else if (r < 36) begin
        press(1'($urandom), 1'($urandom), 1'b1, 1'($urandom), 4'($urandom));
      end else begin
        bit b;
        if ($urandom_range(0, 3) != 0) b = m_key[3 - (m_shifts % 4)];
        else b = 1'($urandom);
        enter(b);
      end
      if ($urandom_range(0, 9) == 0) wait_ticks($urandom_range(0, 20));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/tt_keyverify.md
TT_KEYVERIFY -- requirements
Module: tt_keyverify

Interface
REQ-001 Parameter DENY_CYCLES, default 16: number of clk cycles fail is held after a wrong submit.
REQ-002 Parameter MAX_TRIES, default 3: number of wrong submits that forces lockout.
REQ-003 clk  input  1  single system clock; all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 key_in  input  4  sampled random key, the samplednum of the key generator.
REQ-006 key_load  input  1  asynchronous button; a rising edge captures key_in.
REQ-007 entry_bit  input  1  asynchronous data pin holding the user's next key bit.
REQ-008 entry_clk  input  1  asynchronous button; a rising edge shifts entry_bit in.
REQ-009 submit  input  1  asynchronous button; a rising edge compares entry against key.
REQ-010 match  output  1  high while in GRANT.
REQ-011 fail  output  1  high while in DENY.
REQ-012 locked  output  1  high while in LOCK.
REQ-013 attempts  output  2  count of wrong submits since reset, saturating at MAX_TRIES.
REQ-014 bitcnt  output  3  number of bits entered since the last clear, saturating at 4.

Function
REQ-015 key_load, entry_bit, entry_clk and submit SHALL each pass a 2-flop synchronizer; key_load, entry_clk and submit SHALL also get a rising-edge detect on the synchronized value.
REQ-016 Latency: for a pin first sampled high at clk edge N, the state and registered outputs SHALL update at edge N+2.
REQ-017 FSM states: EMPTY, ENTRY, GRANT, DENY, LOCK.
REQ-018 EMPTY: a key_load edge SHALL capture key_in into key_reg, clear shift_reg and bitcnt, and go to ENTRY; all other edges are ignored.
REQ-019 ENTRY, entry_clk edge: shift_reg SHALL become {shift_reg[2:0], entry_bit} and bitcnt SHALL increment, saturating at 4; shifting continues past 4 and the last 4 bits are kept.
REQ-020 ENTRY, submit edge with bitcnt==4 and shift_reg==key_reg: go to GRANT.
REQ-021 ENTRY, any other submit edge (too few bits or mismatch): increment attempts; if the new value equals MAX_TRIES go to LOCK, else go to DENY.
REQ-022 ENTRY, key_load edge: recapture key_in and clear shift_reg and bitcnt; attempts SHALL be unchanged.
REQ-023 Simultaneous edges in ENTRY: priority SHALL be submit, then key_load, then entry_clk; lower-priority edges in the same cycle are discarded.
REQ-024 DENY: a down-counter SHALL load DENY_CYCLES-1 on entry; at zero, clear shift_reg and bitcnt and return to ENTRY; all button edges are ignored.
REQ-025 GRANT: only a key_load edge is acted on; it SHALL recapture the key, clear the entry and attempts, and go to ENTRY.
REQ-026 LOCK: absorbing; only rst_n SHALL exit it.
REQ-027 match, fail and locked SHALL be registered and mutually exclusive.

Reset
REQ-028 rst_n low SHALL asynchronously force: state EMPTY, key_reg 0, shift_reg 0, bitcnt 0, attempts 0, deny counter 0, all synchronizer and edge flops 0, match, fail and locked 0.
REQ-029 Reset asserted mid-operation (including DENY and LOCK) SHALL discard all progress; an edge already in flight in a synchronizer SHALL NOT act after reset release.

Structure
REQ-030 Package tt_keyverify_pkg SHALL hold the state enum, KEY_W=4, and the default DENY_CYCLES and MAX_TRIES values.
REQ-031 One sub-module, tt_sync_edge (2-flop synchronizer plus registered previous value, outputs level and rise), SHALL be instantiated per button input; entry_bit uses the level output only.

Verification
REQ-032 Reset, key_in=4'b1010 with key_load pulsed, then enter 1,0,1,0 and submit -> match=1 at edge N+2 after the submit is sampled, attempts=0, bitcnt=4.
REQ-033 Key 4'b0110, enter 0,1,1,1 and submit -> fail=1 for exactly 16 cycles, attempts=1, then back in ENTRY with bitcnt=0.
REQ-034 Three wrong submits (the first with only 2 bits entered) -> the third gives locked=1 and attempts=3; further key_load, entry_clk and submit edges are ignored; rst_n low clears everything to 0.
REQ-035 submit and entry_clk rising in the same cycle with bitcnt=3 -> the compare uses 3 bits and counts as a failure; the bit is not shifted.
REQ-036 Key 4'b0011, enter 1,1,0,0,1,1 and submit -> bitcnt stays at 4, shift_reg=4'b0011, match=1.
REQ-037 Assert rst_n low during DENY with the deny counter at 5 -> all outputs are 0 and the state is EMPTY; after release, a submit edge with no key loaded has no effect.
